// File: rtl/plot_arbiter.sv
// Round-robin owner of the vga_adapter write port with a built-in full-screen clear sweep.
// Optional macro PLOT_ARB_INTERLEAVE_EN lets requesters steal single cycles from a running clear.
module plot_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int WIDTH   = 160,
    parameter int HEIGHT  = 120
) (
    input  logic                   CLOCK_50,
    input  logic                   reset_n,
    input  logic                   clear_start,
    input  logic [5:0]             clear_colour,
    output logic                   clear_busy,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_x,
    input  logic [7*NUM_REQ-1:0]   req_y,
    input  logic [6*NUM_REQ-1:0]   req_colour,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             x,
    output logic [6:0]             y,
    output logic [5:0]             colour,
    output logic                   plot,
    output logic                   fsm_state
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0]    X_LAST    = 8'(WIDTH - 1);
    localparam logic [6:0]    Y_LAST    = 7'(HEIGHT - 1);
    localparam logic [PW-1:0] PTR_RESET = PW'(NUM_REQ - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t        state, state_next;
    logic [PW-1:0] last_ptr;
    logic [7:0]    cx;
    logic [6:0]    cy;
    logic [5:0]    fill_colour;

    logic          grant_en, grant_any, transfer, sel_in_range, sweep_last;
    logic [PW-1:0] grant_idx;
    logic [7:0]    sel_x;
    logic [6:0]    sel_y;
    logic [5:0]    sel_colour;
    int            idx;

    // Handshake: a requester's pixel is consumed in the cycle where its req_valid and
    // req_ready are both high; an unserved request must hold x/y/colour until then.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(last_ptr) + 1 + i) % NUM_REQ;
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = PW'(idx);
            end
        end
    end

    always_comb begin
`ifdef PLOT_ARB_INTERLEAVE_EN
        grant_en = (state == IDLE && !clear_start) || (state == CLEAR);
`else
        grant_en = (state == IDLE && !clear_start);
`endif
        transfer  = grant_en && grant_any;
        req_ready = '0;
        if (transfer) req_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        sel_x        = req_x[int'(grant_idx)*8 +: 8];
        sel_y        = req_y[int'(grant_idx)*7 +: 7];
        sel_colour   = req_colour[int'(grant_idx)*6 +: 6];
        sel_in_range = (int'(sel_x) < WIDTH) && (int'(sel_y) < HEIGHT);
        sweep_last   = (cx == X_LAST) && (cy == Y_LAST);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clear_start) state_next = CLEAR;
            CLEAR:   if (!transfer && sweep_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // A granted pixel takes priority over the sweep, which simply holds its position.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            x           <= '0;
            y           <= '0;
            colour      <= '0;
            plot        <= 1'b0;
            last_ptr    <= PTR_RESET;
            cx          <= '0;
            cy          <= '0;
            fill_colour <= '0;
        end else begin
            plot <= 1'b0;
            if (transfer) begin
                last_ptr <= grant_idx;
                if (sel_in_range) begin
                    plot   <= 1'b1;
                    x      <= sel_x;
                    y      <= sel_y;
                    colour <= sel_colour;
                end
            end else if (state == CLEAR) begin
                plot   <= 1'b1;
                x      <= cx;
                y      <= cy;
                colour <= fill_colour;
                if (cx == X_LAST) begin
                    cx <= '0;
                    cy <= cy + 7'd1;
                end else begin
                    cx <= cx + 8'd1;
                end
            end else if (clear_start) begin
                fill_colour <= clear_colour;
                cx          <= '0;
                cy          <= '0;
            end
        end
    end

    assign clear_busy = (state == CLEAR);
    assign fsm_state  = state;

endmodule

// File: tb/tb_plot_arbiter.sv
// Randomised bench for plot_arbiter against a pixel-level reference model.
module tb_plot_arbiter;

    localparam int N = 3;
    localparam int W = 160;
    localparam int H = 120;
`ifdef PLOT_ARB_INTERLEAVE_EN
    localparam bit INTERLEAVE = 1'b1;
`else
    localparam bit INTERLEAVE = 1'b0;
`endif

    logic           CLOCK_50 = 1'b0;
    logic           reset_n  = 1'b1;
    logic           clear_start = 1'b0;
    logic [5:0]     clear_colour = '0;
    logic           clear_busy;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_x = '0;
    logic [7*N-1:0] req_y = '0;
    logic [6*N-1:0] req_colour = '0;
    logic [N-1:0]   req_ready;
    logic [7:0]     x;
    logic [6:0]     y;
    logic [5:0]     colour;
    logic           plot;
    logic           fsm_state;

    plot_arbiter #(.NUM_REQ(N), .WIDTH(W), .HEIGHT(H)) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n),
        .clear_start(clear_start), .clear_colour(clear_colour), .clear_busy(clear_busy),
        .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
        .req_ready(req_ready), .x(x), .y(y), .colour(colour), .plot(plot),
        .fsm_state(fsm_state)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;

    // Requester stimulus
    int rv[N], rx[N], ry[N], rc[N];

    // Reference model: sweep tracked as a linear pixel index
    bit m_clear;
    int m_n, m_col, m_last;
    int e_plot, e_x, e_y, e_col;
    int last_grant;

    // Observed values at the most recent sample point
    logic [N-1:0] obs_ready;
    logic         obs_busy, obs_plot;
    logic [7:0]   obs_x;
    logic [6:0]   obs_y;
    logic [5:0]   obs_col;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            req_valid[i]         = rv[i][0];
            req_x[8*i +: 8]      = 8'(rx[i]);
            req_y[7*i +: 7]      = 7'(ry[i]);
            req_colour[6*i +: 6] = 6'(rc[i]);
        end
    endtask

    function automatic int model_grant();
        bit allow;
        allow = m_clear ? INTERLEAVE : !clear_start;
        if (!allow) return -1;
        for (int i = 1; i <= N; i++) begin
            if (rv[(m_last + i) % N] != 0) return (m_last + i) % N;
        end
        return -1;
    endfunction

    // One clock: sample at negedge, advance the model, return at posedge+1.
    task automatic tick();
        int g;
        @(negedge CLOCK_50);
        obs_ready = req_ready; obs_busy = clear_busy; obs_plot = plot;
        obs_x = x; obs_y = y; obs_col = colour;
        g = model_grant();
        check("req_ready", req_ready, (g >= 0) ? (32'd1 << g) : 32'd0);
        check("clear_busy", clear_busy, m_clear);
        check("plot", plot, e_plot);
        if (e_plot != 0) begin
            check("x", x, e_x);
            check("y", y, e_y);
            check("colour", colour, e_col);
        end
        e_plot = 0;
        if (g >= 0) begin
            m_last = g;
            if (rx[g] < W && ry[g] < H) begin
                e_plot = 1; e_x = rx[g]; e_y = ry[g]; e_col = rc[g];
            end
        end else if (m_clear) begin
            e_plot = 1; e_x = m_n % W; e_y = m_n / W; e_col = m_col;
            m_n++;
            if (m_n == W * H) m_clear = 0;
        end else if (clear_start) begin
            m_clear = 1; m_n = 0; m_col = clear_colour;
        end
        last_grant = g;
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic rand_reqs(input int prob);
        for (int i = 0; i < N; i++) begin
            if (rv[i] == 0 || last_grant == i) begin
                rv[i] = ($urandom_range(99) < prob) ? 1 : 0;
                rx[i] = ($urandom_range(9) == 0) ? $urandom_range(255) : $urandom_range(W - 1);
                ry[i] = ($urandom_range(9) == 0) ? $urandom_range(127) : $urandom_range(H - 1);
                rc[i] = $urandom_range(63);
            end
        end
        apply();
    endtask

    task automatic do_reset();
        clear_start = 0;
        for (int i = 0; i < N; i++) rv[i] = 0;
        apply();
        #2 reset_n = 1'b0;
        #1;
        check("rst_plot", plot, 0);
        check("rst_busy", clear_busy, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_colour", colour, 0);
        check("rst_state", fsm_state, 0);
        check("rst_ready", req_ready, 0);
        m_clear = 0; m_n = 0; m_col = 0; m_last = N - 1;
        e_plot = 0; e_x = 0; e_y = 0; e_col = 0; last_grant = -1;
        @(posedge CLOCK_50);
        @(posedge CLOCK_50);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        int t2_seq[6];
        int plots, grant_at, busy_cnt;
        t2_seq = '{1, 2, 4, 1, 2, 4};
        for (int i = 0; i < N; i++) begin rv[i] = 0; rx[i] = 0; ry[i] = 0; rc[i] = 0; end

        // Single request from reset
        do_reset();
        rv[0] = 1; rx[0] = 10; ry[0] = 20; rc[0] = 6'b110100; apply();
        tick();
        check("t1_ready", obs_ready, 3'b001);
        rv[0] = 0; apply();
        tick();
        check("t1_x", obs_x, 10);
        check("t1_y", obs_y, 20);
        check("t1_colour", obs_col, 6'b110100);
        tick();
        check("t1_plot_low", obs_plot, 0);

        // All three requesting: strict rotation from reset
        do_reset();
        for (int i = 0; i < N; i++) begin rv[i] = 1; rx[i] = i + 1; ry[i] = i + 1; rc[i] = i + 1; end
        apply();
        for (int k = 0; k < 6; k++) begin
            tick();
            check("t2_grant", obs_ready, t2_seq[k]);
        end
        for (int i = 0; i < N; i++) rv[i] = 0;
        apply();
        tick();

        // Out-of-range request is consumed without a plot
        rv[0] = 1; rx[0] = 160; ry[0] = 5; rc[0] = 7; apply();
        tick();
        check("t5_ready_oor", obs_ready, 3'b001);
        rx[0] = 159; ry[0] = 119; apply();
        tick();
        check("t5_noplot", obs_plot, 0);
        rv[0] = 0; apply();
        tick();
        check("t5_plot", obs_plot, 1);
        check("t5_x", obs_x, 159);
        check("t5_y", obs_y, 119);

        // Full-screen clear
        clear_start = 1; clear_colour = 6'b010101;
        plots = 0;
        for (int k = 0; k < 19300; k++) begin
            tick();
            if (k == 0) clear_start = 0;
            plots += int'(obs_plot);
            if (k == 2) begin
                check("t3_first_x", obs_x, 0);
                check("t3_first_y", obs_y, 0);
                check("t3_first_col", obs_col, 6'b010101);
            end
            if (k == 3) check("t3_second_x", obs_x, 1);
            if (k == 2 + W) begin
                check("t3_161_x", obs_x, 0);
                check("t3_161_y", obs_y, 1);
            end
            if (k > 0 && !obs_busy) begin
                check("t3_last_x", obs_x, W - 1);
                check("t3_last_y", obs_y, H - 1);
                break;
            end
        end
        check("t3_plots", plots, W * H);

        // Request arriving with clear_start
        rv[0] = 1; rx[0] = 7; ry[0] = 8; rc[0] = 9;
        clear_start = 1; clear_colour = 6'h2a; apply();
        grant_at = -1; busy_cnt = 0;
        for (int k = 0; k < 20000; k++) begin
            tick();
            if (k == 0) clear_start = 0;
            if (obs_ready[0] && grant_at < 0) begin
                grant_at = k; rv[0] = 0;
            end
            busy_cnt += int'(obs_busy);
            apply();
            if (grant_at >= 0 && !m_clear && k > 0) break;
        end
        check("t4_grant_at", grant_at, INTERLEAVE ? 1 : W * H + 1);
        check("t4_busy_cycles", busy_cnt, INTERLEAVE ? W * H + 1 : W * H);
        tick();

        // Reset in the middle of a clear, then restart from the origin
        clear_start = 1; clear_colour = 6'h3f;
        for (int k = 0; k < 5000; k++) begin
            tick();
            clear_start = 0;
        end
        do_reset();
        clear_start = 1; clear_colour = 6'h11;
        for (int k = 0; k < 4; k++) begin
            tick();
            clear_start = 0;
            if (k == 2) begin
                check("t6_restart_x", obs_x, 0);
                check("t6_restart_y", obs_y, 0);
            end
        end
        do_reset();

        // Random request traffic
        for (int k = 0; k < 1500; k++) begin
            tick();
            rand_reqs(60);
        end

        // Random traffic across a clear, with ignored restart attempts
        clear_start = 1; clear_colour = 6'(32'($urandom_range(63)));
        for (int k = 0; k < 21000; k++) begin
            tick();
            clear_start = (m_clear && m_n < W * H - 10 && $urandom_range(99) == 0);
            rand_reqs(30);
            if (k > 0 && !m_clear) break;
        end
        clear_start = 0;
        check("t7_clear_done", m_clear, 0);
        for (int i = 0; i < N; i++) rv[i] = 0;
        apply();
        for (int k = 0; k < 3; k++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
